// File: rtl/oam_dma_if.sv
// Bus bundle between the sprite DMA engine, the 6502 core and the memory map.
// The master side is the CPU/memory map. The slave side is the DMA engine.
interface oam_dma_if;
  logic        cyc_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_r_nw;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_r_nw;
  logic [7:0]  bus_data_in;
  logic        dma_active;
  logic        dma_done;

  modport master (
    output cyc_en, cpu_addr, cpu_data_out, cpu_r_nw, bus_data_in,
    input  cpu_rdy, bus_addr, bus_data_out, bus_r_nw, dma_active, dma_done
  );

  modport slave (
    input  cyc_en, cpu_addr, cpu_data_out, cpu_r_nw, bus_data_in,
    output cpu_rdy, bus_addr, bus_data_out, bus_r_nw, dma_active, dma_done
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to $4014 halts the core and copies page $XX00-$XXFF into $2004.
// Define OAM_DMA_ALIGN_EN to insert a dummy read when the copy would start on an odd cycle.
//
//   state | meaning
//   IDLE  | bus follows CPU, waiting for a write to $4014
//   HALT  | CPU held, bus still follows CPU for one cycle
//   ALIGN | dummy read of {page,idx} to land reads on "get" cycles
//   READ  | read {page,idx} into buf_q
//   WRITE | write buf_q to $2004, advance idx
module oam_dma (
  input  logic       sys_clock,
  input  logic       rst,
  oam_dma_if.slave   mif
);
  localparam logic [15:0] OAM_PORT = 16'h2004;
  localparam logic [15:0] DMA_REG  = 16'h4014;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
`ifdef OAM_DMA_ALIGN_EN
    S_ALIGN,
`endif
    S_READ,
    S_WRITE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] page, page_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] buf_q, buf_nxt;
  logic       parity;

  always_ff @(posedge sys_clock or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      page   <= 8'h00;
      idx    <= 8'h00;
      buf_q  <= 8'h00;
      parity <= 1'b0;
    end else if (mif.cyc_en) begin
      state  <= state_nxt;
      page   <= page_nxt;
      idx    <= idx_nxt;
      buf_q  <= buf_nxt;
      parity <= ~parity;
    end
  end

  always_comb begin
    state_nxt        = state;
    page_nxt         = page;
    idx_nxt          = idx;
    buf_nxt          = buf_q;
    mif.cpu_rdy      = 1'b0;
    mif.dma_active   = 1'b0;
    mif.dma_done     = 1'b0;
    mif.bus_addr     = mif.cpu_addr;
    mif.bus_data_out = mif.cpu_data_out;
    mif.bus_r_nw     = mif.cpu_r_nw;

    case (state)
      S_IDLE: begin
        mif.cpu_rdy = 1'b1;
        if (!mif.cpu_r_nw && (mif.cpu_addr == DMA_REG)) begin
          page_nxt  = mif.cpu_data_out;
          idx_nxt   = 8'h00;
          state_nxt = S_HALT;
        end
      end
      S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        state_nxt = parity ? S_ALIGN : S_READ;
`else
        state_nxt = S_READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      S_ALIGN: begin
        mif.dma_active   = 1'b1;
        mif.bus_addr     = {page, idx};
        mif.bus_r_nw     = 1'b1;
        mif.bus_data_out = buf_q;
        state_nxt        = S_READ;
      end
`endif
      S_READ: begin
        mif.dma_active   = 1'b1;
        mif.bus_addr     = {page, idx};
        mif.bus_r_nw     = 1'b1;
        mif.bus_data_out = buf_q;
        buf_nxt          = mif.bus_data_in;
        state_nxt        = S_WRITE;
      end
      S_WRITE: begin
        mif.dma_active   = 1'b1;
        mif.bus_addr     = OAM_PORT;
        mif.bus_r_nw     = 1'b0;
        mif.bus_data_out = buf_q;
        idx_nxt          = idx + 8'h01;
        // completion is judged on the pre-increment index so the copy never leaves the page
        if (idx == 8'hFF) begin
          mif.dma_done = mif.cyc_en;
          state_nxt    = S_IDLE;
        end else begin
          state_nxt = S_READ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus queues expected bus cycles, a monitor checks each CPU cycle.
module tb_oam_dma;
`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic sys_clock = 1'b0;
  logic rst = 1'b1;

  oam_dma_if mif();

  oam_dma dut (
    .sys_clock (sys_clock),
    .rst       (rst),
    .mif       (mif)
  );

  always #5 sys_clock = ~sys_clock;

  logic [7:0] mem [0:65535];
  assign mif.bus_data_in = mem[mif.bus_addr];

  typedef struct {
    bit          rnw;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t exp_q [$];
  int   errors = 0;
  int   checks = 0;
  int   n_steps = 0;
  int   rdy_low = 0;
  int   done_cnt = 0;
  int   wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // cyc_en: one-clock pulses with random gaps
  initial begin
    mif.cyc_en = 1'b0;
    forever begin
      repeat ($urandom_range(1, 3)) @(posedge sys_clock);
      #1 mif.cyc_en = 1'b1;
      @(posedge sys_clock);
      #1 mif.cyc_en = 1'b0;
    end
  end

  // CPU cycles completed since reset; the DUT parity is the low bit of this
  always @(posedge sys_clock or posedge rst) begin
    if (rst) n_steps <= 0;
    else if (mif.cyc_en) n_steps <= n_steps + 1;
  end

  // monitor: judges the bus cycle that the upcoming cyc_en edge completes
  always @(negedge sys_clock) begin
    txn_t t;
    if (mif.cyc_en && !rst) begin
      if (!mif.cpu_rdy) rdy_low++;
      if (mif.dma_done) done_cnt++;
      if (mif.dma_active) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: got addr %0h rnw %0b, expected none at %0t",
                   mif.bus_addr, mif.bus_r_nw, $time);
        end else begin
          t = exp_q.pop_front();
          chk("dma_addr", mif.bus_addr, t.addr);
          chk("dma_rnw", mif.bus_r_nw, t.rnw);
          if (!t.rnw) begin
            chk("dma_wdata", mif.bus_data_out, t.data);
            wr_seen++;
          end
        end
      end else begin
        chk("pass_addr", mif.bus_addr, mif.cpu_addr);
        chk("pass_rnw", mif.bus_r_nw, mif.cpu_r_nw);
        chk("pass_data", mif.bus_data_out, mif.cpu_data_out);
      end
    end
  end

  task automatic step();
    do @(posedge sys_clock); while (mif.cyc_en !== 1'b1);
    #2;
  endtask

  task automatic cpu_set(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    mif.cpu_addr     = a;
    mif.cpu_data_out = d;
    mif.cpu_r_nw     = rnw;
  endtask

  task automatic cpu_idle();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == 16'h4014) a = 16'h4015;
    cpu_set(a, 8'($urandom), 1'($urandom));
  endtask

  // steer so that the HALT cycle lands on the wanted parity (-1 = don't care)
  task automatic steer(input int want_par);
    if (want_par >= 0) begin
      while (((n_steps + 1) & 1) != want_par) begin
        cpu_idle();
        step();
      end
    end
  endtask

  task automatic expect_page(input logic [7:0] page, input bit align);
    txn_t t;
    if (align) begin
      t.rnw = 1'b1; t.addr = {page, 8'h00}; t.data = 8'h00;
      exp_q.push_back(t);
    end
    for (int i = 0; i < 256; i++) begin
      t.rnw = 1'b1; t.addr = {page, 8'(i)}; t.data = 8'h00;
      exp_q.push_back(t);
      t.rnw = 1'b0; t.addr = 16'h2004; t.data = mem[{page, 8'(i)}];
      exp_q.push_back(t);
    end
  endtask

  task automatic transfer(input logic [7:0] page, input int want_par, input bit noise_trig);
    bit align;
    int r0, d0, k;
    steer(want_par);
    align = ALIGN_EN && (((n_steps + 1) & 1) == 1);
    expect_page(page, align);
    r0 = rdy_low;
    d0 = done_cnt;
    cpu_set(16'h4014, page, 1'b0);
    step();
    if (noise_trig) cpu_set(16'h4014, 8'($urandom), 1'b0);
    else cpu_idle();
    for (k = 0; k < 600; k++) begin
      step();
      if (done_cnt != d0) break;
    end
    cpu_idle();
    chk("halt_cycles", 32'(rdy_low - r0), align ? 32'd514 : 32'd513);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    step();
    chk("rdy_after", mif.cpu_rdy, 1'b1);
  endtask

  task automatic abort_transfer(input logic [7:0] page);
    int w0, k;
    steer(0);
    expect_page(page, 1'b0);
    w0 = wr_seen;
    cpu_set(16'h4014, page, 1'b0);
    step();
    cpu_idle();
    for (k = 0; k < 600 && (wr_seen - w0) < 128; k++) step();
    step();
    chk("abort_in_write", mif.bus_addr, 16'h2004);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_rdy", mif.cpu_rdy, 1'b1);
    chk("abort_active", mif.dma_active, 1'b0);
    chk("abort_pass", mif.bus_addr, mif.cpu_addr);
    repeat (4) @(posedge sys_clock);
    @(negedge sys_clock) rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cpu_idle();
      step();
    end
    chk("abort_no_writes", 32'(wr_seen - w0), 32'd128);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'h5A;

    cpu_set(16'h1234, 8'h77, 1'b1);
    repeat (6) @(posedge sys_clock);
    #2;
    chk("rst_rdy", mif.cpu_rdy, 1'b1);
    chk("rst_active", mif.dma_active, 1'b0);
    chk("rst_done", mif.dma_done, 1'b0);
    chk("rst_addr", mif.bus_addr, 16'h1234);
    // a trigger while reset is held must be lost
    cpu_set(16'h4014, 8'h03, 1'b0);
    repeat (6) @(posedge sys_clock);
    #2;
    chk("rst_trig_rdy", mif.cpu_rdy, 1'b1);
    chk("rst_trig_active", mif.dma_active, 1'b0);
    cpu_set(16'h1234, 8'h00, 1'b1);
    @(negedge sys_clock) rst = 1'b0;
    step();
    chk("idle_rdy", mif.cpu_rdy, 1'b1);

    transfer(8'h03, 0, 1'b0);
    transfer(8'h03, 1, 1'b0);
    transfer(8'hFF, -1, 1'b0);
    transfer(8'h03, 0, 1'b1);
    abort_transfer(8'h03);
    transfer(8'h05, -1, 1'b0);

    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 5)) begin
        cpu_idle();
        step();
      end
      transfer(8'($urandom), $urandom_range(0, 1), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
